// File: rtl/systolic_feeder_pkg.sv
// Shared state encoding, default geometry and helpers for the systolic array feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {FILL, WLOAD, STREAM, DRAIN} state_e;

  localparam int DEPTH_DEF  = 3;
  localparam int SIZE_DEF   = 3;
  localparam int BW_DEF     = 8;
  localparam int DRAIN_DEF  = 6;

  // Upper bounds for the generic lane() helper.
  localparam int VEC_MAX    = 1024;
  localparam int ELEM_MAX   = 64;

  // Width of a counter that must hold max(depth, size+depth, drain_cycles).
  function automatic int cnt_width(input int d, input int s, input int dr);
    int m;
    m = d;
    if (s + d > m) m = s + d;
    if (dr > m) m = dr;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEPTH_DEF, SIZE_DEF, DRAIN_DEF);

  // Element k of a packed row of bw-bit elements, zero-extended to ELEM_MAX.
  function automatic logic [ELEM_MAX-1:0] lane(input logic [VEC_MAX-1:0] vec,
                                               input int k, input int bw);
    logic [ELEM_MAX-1:0] mask;
    mask = (bw >= ELEM_MAX) ? '1 : ((ELEM_MAX'(1) << bw) - ELEM_MAX'(1));
    return ELEM_MAX'(vec >> (k * bw)) & mask;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One activation lane: presents abuf[t-k] element k inside the skew window, else 0.
module systolic_feeder_skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int k         = 0,
  parameter int size      = SIZE_DEF,
  parameter int bit_width = BW_DEF,
  parameter int cnt_w     = CNT_W_DEF
) (
  input  logic                      en_i,
  input  logic [cnt_w-1:0]          t_i,
  input  logic [bit_width*size-1:0] col_i,
  output logic [bit_width-1:0]      elem_o
);

  always_comb begin
    elem_o = '0;
    for (int r = 0; r < size; r++) begin
      if (en_i && (int'(t_i) == r + k)) begin
        elem_o = bit_width'(lane(VEC_MAX'(col_i), r, bit_width));
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Collects a weight tile and an activation tile, then sequences weight shift,
// skewed activation streaming and drain for a weight-stationary MAC array.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int depth        = DEPTH_DEF,
  parameter int size         = SIZE_DEF,
  parameter int bit_width    = BW_DEF,
  parameter int drain_cycles = DRAIN_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [bit_width*depth-1:0] in_row,
  output logic                       control,
  output logic [bit_width*depth-1:0] wt_arr,
  output logic [bit_width*depth-1:0] data_arr,
  output logic                       busy,
  output logic                       tile_done
);

  localparam int RW = bit_width * depth;
  localparam int CW = cnt_width(depth, size, drain_cycles);

  state_e        state_q, state_d;
  logic [CW-1:0] wt_cnt_q, wt_cnt_d;
  logic [CW-1:0] act_cnt_q, act_cnt_d;
  logic [CW-1:0] phase_q, phase_d;

  logic [RW-1:0] wbuf_q [depth];
  logic [RW-1:0] abuf_q [size];

  logic          wt_full, act_full, accept, wt_wr, act_wr, stream_en;
  logic [RW-1:0] wt_sel, data_d;
  logic [bit_width*size-1:0] col [depth];

  logic          control_q, busy_q, tile_done_q;
  logic [RW-1:0] wt_arr_q, data_arr_q;

  assign wt_full  = (wt_cnt_q == CW'(depth));
  assign act_full = (act_cnt_q == CW'(size));
  assign in_ready = !reset && (state_q == FILL) && !(in_sel ? act_full : wt_full);
  assign accept   = in_valid && in_ready;
  assign wt_wr    = accept && !in_sel;
  assign act_wr   = accept && in_sel;

  always_ff @(posedge clk) begin
    for (int r = 0; r < depth; r++) begin
      if (wt_wr && (wt_cnt_q == CW'(r))) wbuf_q[r] <= in_row;
    end
    for (int r = 0; r < size; r++) begin
      if (act_wr && (act_cnt_q == CW'(r))) abuf_q[r] <= in_row;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wt_cnt_d  = wt_cnt_q;
    act_cnt_d = act_cnt_q;
    case (state_q)
      FILL: begin
        if (wt_wr)  wt_cnt_d  = wt_cnt_q + CW'(1);
        if (act_wr) act_cnt_d = act_cnt_q + CW'(1);
        if (accept && (wt_cnt_d == CW'(depth)) && (act_cnt_d == CW'(size))) begin
          state_d = WLOAD;
          phase_d = '0;
        end
      end
      WLOAD: begin
        if (phase_q == CW'(depth - 1)) begin
          state_d = STREAM;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      STREAM: begin
        if (phase_q == CW'(size + depth - 2)) begin
          state_d = DRAIN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      DRAIN: begin
        if (phase_q == CW'(drain_cycles - 1)) begin
          state_d   = FILL;
          phase_d   = '0;
          wt_cnt_d  = '0;
          act_cnt_d = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  // The final weight row may be written on the very edge that enters WLOAD,
  // and it is the first one shifted out, so forward it straight from in_row.
  always_comb begin
    wt_sel = '0;
    for (int r = 0; r < depth; r++) begin
      if (phase_d == CW'(depth - 1 - r)) begin
        wt_sel = (wt_wr && (wt_cnt_q == CW'(r))) ? in_row : wbuf_q[r];
      end
    end
  end

  assign stream_en = (state_d == STREAM);

  for (genvar gi = 0; gi < depth; gi++) begin : g_lane
    for (genvar gr = 0; gr < size; gr++) begin : g_col
      assign col[gi][gr*bit_width +: bit_width] = abuf_q[gr][gi*bit_width +: bit_width];
    end

    systolic_feeder_skew_lane #(
      .k         (gi),
      .size      (size),
      .bit_width (bit_width),
      .cnt_w     (CW)
    ) u_skew (
      .en_i   (stream_en),
      .t_i    (phase_d),
      .col_i  (col[gi]),
      .elem_o (data_d[gi*bit_width +: bit_width])
    );
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      phase_q     <= '0;
      wt_cnt_q    <= '0;
      act_cnt_q   <= '0;
      control_q   <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      wt_arr_q    <= '0;
      data_arr_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wt_cnt_q    <= wt_cnt_d;
      act_cnt_q   <= act_cnt_d;
      control_q   <= (state_d == WLOAD);
      busy_q      <= (state_d != FILL);
      tile_done_q <= (state_d == DRAIN) && (phase_d == CW'(drain_cycles - 1));
      wt_arr_q    <= (state_d == WLOAD) ? wt_sel : '0;
      data_arr_q  <= data_d;
    end
  end

  assign control   = control_q;
  assign busy      = busy_q;
  assign tile_done = tile_done_q;
  assign wt_arr    = wt_arr_q;
  assign data_arr  = data_arr_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder, with a degenerate 1x1 instance.
`timescale 1ns/1ps
module tb_systolic_feeder;

  localparam int D  = 3;
  localparam int S  = 3;
  localparam int BW = 8;
  localparam int DR = 6;
  localparam int RW = D * BW;
  localparam int NT = D + (S + D - 1) + DR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sel = 1'b0;
  logic [RW-1:0] in_row = '0;
  logic          in_ready, control, busy, tile_done;
  logic [RW-1:0] wt_arr, data_arr;

  logic          d_in_valid = 1'b0;
  logic          d_in_sel = 1'b0;
  logic [BW-1:0] d_in_row = '0;
  logic          d_in_ready, d_control, d_busy, d_done;
  logic [BW-1:0] d_wt, d_data;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] tw [2][D];
  logic [RW-1:0] ta [2][S];
  logic          ord_sel [2][D+S];

  logic          cap_ctrl [32];
  logic          cap_busy [32];
  logic          cap_done [32];
  logic          cap_rdy  [32];
  logic [RW-1:0] cap_wt   [32];
  logic [RW-1:0] cap_data [32];
  int            mac_res  [S][D];

  always #5 clk = ~clk;

  systolic_feeder #(.depth(D), .size(S), .bit_width(BW), .drain_cycles(DR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_row(in_row), .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
    .busy(busy), .tile_done(tile_done)
  );

  systolic_feeder #(.depth(1), .size(1), .bit_width(BW), .drain_cycles(DR)) dut_deg (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_sel(d_in_sel),
    .in_row(d_in_row), .control(d_control), .wt_arr(d_wt), .data_arr(d_data),
    .busy(d_busy), .tile_done(d_done)
  );

  function automatic logic [RW-1:0] pack3(input int e0, input int e1, input int e2);
    return {BW'(e2), BW'(e1), BW'(e0)};
  endfunction

  // Row sent at position p: the n-th row of its kind goes to buffer slot n.
  function automatic logic [RW-1:0] row_at(input int slot, input int p);
    int n = 0;
    for (int q = 0; q < p; q++) if (ord_sel[slot][q] == ord_sel[slot][p]) n++;
    return ord_sel[slot][p] ? ta[slot][n] : tw[slot][n];
  endfunction

  // Cycle c (1 = first cycle after FILL exit): weights leave last-row-first.
  function automatic logic [RW-1:0] exp_wt(input int slot, input int c);
    if (c >= 1 && c <= D) return tw[slot][D-c];
    return '0;
  endfunction

  // Activation A[i][k] appears on lane k at stream step i+k.
  function automatic logic [RW-1:0] exp_data(input int slot, input int c);
    logic [RW-1:0] v = '0;
    int t = c - 1 - D;
    for (int i = 0; i < S; i++)
      for (int k = 0; k < D; k++)
        if (t >= 0 && t == i + k) v[k*BW +: BW] = ta[slot][i][k*BW +: BW];
    return v;
  endfunction

  // Behavioural weight-stationary array fed with the captured outputs.
  function automatic void fill_mac();
    logic [RW-1:0] arr [D];
    for (int r = 0; r < D; r++) arr[r] = '0;
    for (int i = 0; i < S; i++) for (int j = 0; j < D; j++) mac_res[i][j] = 0;
    for (int c = 1; c <= D; c++) begin
      if (cap_ctrl[c]) begin
        for (int r = D - 1; r > 0; r--) arr[r] = arr[r-1];
        arr[0] = cap_wt[c];
      end
    end
    for (int c = D + 1; c <= D + S + D - 1; c++) begin
      for (int k = 0; k < D; k++) begin
        int i = c - D - 1 - k;
        if (i >= 0 && i < S)
          for (int j = 0; j < D; j++)
            mac_res[i][j] += int'(cap_data[c][k*BW +: BW]) * int'(arr[k][j*BW +: BW]);
      end
    end
  endfunction

  function automatic int ref_mac(input int slot, input int i, input int j);
    int acc = 0;
    for (int k = 0; k < D; k++)
      acc += int'(ta[slot][i][k*BW +: BW]) * int'(tw[slot][k][j*BW +: BW]);
    return acc;
  endfunction

  task automatic rand_tile(input int slot);
    for (int r = 0; r < D; r++)
      for (int e = 0; e < D; e++) tw[slot][r][e*BW +: BW] = BW'($urandom_range(255, 0));
    for (int r = 0; r < S; r++)
      for (int e = 0; e < D; e++) ta[slot][r][e*BW +: BW] = BW'($urandom_range(255, 0));
    for (int p = 0; p < D + S; p++) ord_sel[slot][p] = (p >= D);
    for (int p = D + S - 1; p > 0; p--) begin
      int j;
      logic tmp;
      j = int'($urandom_range(p, 0));
      tmp = ord_sel[slot][p];
      ord_sel[slot][p] = ord_sel[slot][j];
      ord_sel[slot][j] = tmp;
    end
  endtask

  task automatic send_rows(input int slot, input int from, input int to);
    for (int p = from; p < to; p++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = ord_sel[slot][p];
      in_row   = row_at(slot, p);
      #1;
      while (!in_ready && waited < 50) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout slot=%0d pos=%0d in_ready=%0b required=1", slot, p, in_ready);
      end
      @(posedge clk);
      #1;
      $display("row slot=%0d pos=%0d sel=%0b data=%h", slot, p, in_sel, in_row);
    end
    in_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_ctrl[c] = control;
      cap_busy[c] = busy;
      cap_done[c] = tile_done;
      cap_rdy[c]  = in_ready;
      cap_wt[c]   = wt_arr;
      cap_data[c] = data_arr;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_sel = 1'b0; in_row = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if ({control, busy, tile_done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {control, busy, tile_done}); end
    checks++; if (wt_arr !== '0 || data_arr !== '0) begin errors++; $display("FAIL reset_lanes wt=%h data=%h exp=0", wt_arr, data_arr); end
    checks++; if ({d_control, d_busy, d_done, d_wt, d_data} !== '0) begin errors++; $display("FAIL reset_deg got=%b exp=0", {d_control, d_busy, d_done, d_wt, d_data}); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
    in_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_tile_load();
    logic [RW-1:0] wexp [4];
    logic [RW-1:0] dexp [6];
    tw[0][0] = pack3(1, 2, 3); tw[0][1] = pack3(4, 5, 6); tw[0][2] = pack3(7, 8, 9);
    ta[0][0] = pack3(1, 0, 0); ta[0][1] = pack3(0, 1, 0); ta[0][2] = pack3(0, 0, 1);
    for (int p = 0; p < D + S; p++) ord_sel[0][p] = (p >= D);
    wexp[1] = pack3(7, 8, 9); wexp[2] = pack3(4, 5, 6); wexp[3] = pack3(1, 2, 3);
    dexp[1] = pack3(1, 0, 0); dexp[2] = '0; dexp[3] = pack3(0, 1, 0);
    dexp[4] = '0; dexp[5] = pack3(0, 0, 1);
    send_rows(0, 0, D + S);
    in_valid = 1'b1; in_sel = 1'b1; in_row = pack3(9, 9, 9);
    capture(NT + 1);
    in_valid = 1'b0;
    for (int c = 1; c <= NT + 1; c++) begin
      logic [RW-1:0] ew, ed;
      ew = (c <= D) ? wexp[c] : '0;
      ed = (c > D && c <= D + S + D - 1) ? dexp[c-D] : '0;
      checks++; if (cap_ctrl[c] !== (c <= D)) begin errors++; $display("FAIL load_control c=%0d got=%0b exp=%0b", c, cap_ctrl[c], (c <= D)); end
      checks++; if (cap_wt[c] !== ew) begin errors++; $display("FAIL load_wt c=%0d got=%h exp=%h", c, cap_wt[c], ew); end
      checks++; if (cap_data[c] !== ed) begin errors++; $display("FAIL skew_data c=%0d got=%h exp=%h", c, cap_data[c], ed); end
      checks++; if (cap_done[c] !== (c == NT)) begin errors++; $display("FAIL load_done c=%0d got=%0b exp=%0b", c, cap_done[c], (c == NT)); end
      checks++; if (cap_busy[c] !== (c <= NT)) begin errors++; $display("FAIL load_busy c=%0d got=%0b exp=%0b", c, cap_busy[c], (c <= NT)); end
      checks++; if (cap_rdy[c] !== (c > NT)) begin errors++; $display("FAIL load_ready c=%0d got=%0b exp=%0b", c, cap_rdy[c], (c > NT)); end
    end
    $display("test_tile_load done");
  endtask

  task automatic test_reset_mid_stream();
    int pulses;
    rand_tile(0);
    send_rows(0, 0, D + S);
    capture(D + 3);
    checks++; if (cap_data[D+3] !== exp_data(0, D + 3)) begin errors++; $display("FAIL midrst_pre_data got=%h exp=%h", cap_data[D+3], exp_data(0, D + 3)); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({control, busy, tile_done} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl got=%b exp=000", {control, busy, tile_done}); end
    checks++; if (wt_arr !== '0 || data_arr !== '0) begin errors++; $display("FAIL midrst_lanes wt=%h data=%h exp=0", wt_arr, data_arr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%0b exp=0", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_wt_cnt_clear ready=%0b exp=1", in_ready); end
    in_sel = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_act_cnt_clear ready=%0b exp=1", in_ready); end
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (tile_done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done cycles_active=%0d exp=0", pulses); end
    $display("test_reset_mid_stream done");
  endtask

  task automatic test_interleave_stall();
    rand_tile(0);
    for (int p = 0; p < D + S; p++) ord_sel[0][p] = (p < S);
    send_rows(0, 0, S);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b1; in_row = pack3(8'hab, 8'hcd, 8'hef);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got=%0b exp=0", c, in_ready); end
    end
    send_rows(0, S, D + S);
    capture(NT + 1);
    for (int c = 1; c <= NT + 1; c++) begin
      checks++; if (cap_wt[c] !== exp_wt(0, c)) begin errors++; $display("FAIL inter_wt c=%0d got=%h exp=%h", c, cap_wt[c], exp_wt(0, c)); end
      checks++; if (cap_data[c] !== exp_data(0, c)) begin errors++; $display("FAIL inter_data c=%0d got=%h exp=%h", c, cap_data[c], exp_data(0, c)); end
      checks++; if (cap_done[c] !== (c == NT)) begin errors++; $display("FAIL inter_done c=%0d got=%0b exp=%0b", c, cap_done[c], (c == NT)); end
    end
    $display("test_interleave_stall done");
  endtask

  task automatic test_back_to_back();
    for (int round = 0; round < 3; round++) begin
      rand_tile(0);
      rand_tile(1);
      send_rows(0, 0, D + S);
      in_valid = 1'b1; in_sel = ord_sel[1][0]; in_row = row_at(1, 0);
      capture(NT);
      fill_mac();
      for (int c = 1; c <= NT; c++) begin
        checks++; if (cap_rdy[c] !== 1'b0) begin errors++; $display("FAIL b2b_ready r=%0d c=%0d got=%0b exp=0", round, c, cap_rdy[c]); end
        checks++; if (cap_done[c] !== (c == NT)) begin errors++; $display("FAIL b2b_done1 r=%0d c=%0d got=%0b exp=%0b", round, c, cap_done[c], (c == NT)); end
      end
      for (int i = 0; i < S; i++)
        for (int j = 0; j < D; j++) begin
          checks++; if (mac_res[i][j] !== ref_mac(0, i, j)) begin errors++; $display("FAIL b2b_mac1 r=%0d i=%0d j=%0d got=%0d exp=%0d", round, i, j, mac_res[i][j], ref_mac(0, i, j)); end
        end
      send_rows(1, 0, D + S);
      capture(NT + 1);
      fill_mac();
      for (int c = 1; c <= NT + 1; c++) begin
        checks++; if (cap_done[c] !== (c == NT)) begin errors++; $display("FAIL b2b_done2 r=%0d c=%0d got=%0b exp=%0b", round, c, cap_done[c], (c == NT)); end
      end
      for (int i = 0; i < S; i++)
        for (int j = 0; j < D; j++) begin
          checks++; if (mac_res[i][j] !== ref_mac(1, i, j)) begin errors++; $display("FAIL b2b_mac2 r=%0d i=%0d j=%0d got=%0d exp=%0d", round, i, j, mac_res[i][j], ref_mac(1, i, j)); end
        end
      $display("test_back_to_back round=%0d done", round);
    end
  endtask

  task automatic test_degenerate();
    @(negedge clk);
    d_in_valid = 1'b1; d_in_sel = 1'b0; d_in_row = 8'd5; #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL deg_ready_w got=%0b exp=1", d_in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    d_in_sel = 1'b1; d_in_row = 8'd3; #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL deg_ready_a got=%0b exp=1", d_in_ready); end
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    for (int c = 1; c <= 3 + DR; c++) begin
      logic [BW-1:0] ew, ed;
      @(negedge clk);
      ew = (c == 1) ? 8'd5 : 8'd0;
      ed = (c == 2) ? 8'd3 : 8'd0;
      checks++; if (d_control !== (c == 1)) begin errors++; $display("FAIL deg_control c=%0d got=%0b exp=%0b", c, d_control, (c == 1)); end
      checks++; if (d_wt !== ew) begin errors++; $display("FAIL deg_wt c=%0d got=%0d exp=%0d", c, d_wt, ew); end
      checks++; if (d_data !== ed) begin errors++; $display("FAIL deg_data c=%0d got=%0d exp=%0d", c, d_data, ed); end
      checks++; if (d_done !== (c == 2 + DR)) begin errors++; $display("FAIL deg_done c=%0d got=%0b exp=%0b", c, d_done, (c == 2 + DR)); end
    end
    $display("test_degenerate done");
  endtask

  initial begin
    test_reset();
    test_tile_load();
    test_reset_mid_stream();
    test_interleave_stall();
    test_back_to_back();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
